// File: rtl/synth_io_harness_gen.sv
`default_nettype none
// ============================================================================
// Module  : synth_io_harness_gen
// Brief   : Serial-in/serial-out synthesis harness: deserialises DUT inputs,
//           compresses DUT outputs into a MISR and shifts the signature out.
// Rev     : 1.0
// ============================================================================
module synth_io_harness_gen #(
    parameter int          IN_W  = 365,
    parameter int          OUT_W = 354,
    parameter int          SIG_W = 32,
    parameter logic [31:0] POLY  = 32'h04C11DB7,
    parameter int          MODE  = 0,
    parameter int          CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             serial_in,
    input  logic             shift_en,
    input  logic             start,
    input  logic             dump,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             serial_out,
    output logic             dump_done,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int               c_NUM_CHUNKS  = (OUT_W + SIG_W - 1) / SIG_W;
    localparam int               c_PAD_W       = c_NUM_CHUNKS * SIG_W;
    localparam int               c_BIT_CNT_W   = $clog2(SIG_W + 1);
    localparam logic [SIG_W-1:0] c_POLY        = POLY[SIG_W-1:0];

    localparam logic [1:0]       c_stateIdle   = 2'd0;
    localparam logic [1:0]       c_stateRun    = 2'd1;
    localparam logic [1:0]       c_stateDump   = 2'd2;

    logic [IN_W-1:0]        r_inSr;
    logic [OUT_W-1:0]       w_outSrc;
    logic [OUT_W-1:0]       r_outQ;
    logic [c_PAD_W-1:0]     w_padded;
    logic [SIG_W-1:0]       w_fold;
    logic [SIG_W-1:0]       w_sigNext;
    logic [SIG_W-1:0]       r_sig;
    logic [SIG_W-1:0]       r_dumpSr;
    logic [c_BIT_CNT_W-1:0] r_bitCnt;
    logic [CNT_W-1:0]       r_cycleCount;
    logic [1:0]             r_state;
    logic                   r_serialOut;
    logic                   r_dumpDone;
    logic                   r_busy;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_inSr <= '0;
        end else if (shift_en) begin
            r_inSr <= {serial_in, r_inSr[IN_W-1:1]};
        end
    end

    assign dut_in = r_inSr;

    generate
        if (MODE == 0) begin : g_loopback
            logic w_unusedDutOut;
            assign w_unusedDutOut = ^dut_out;
            if (OUT_W > IN_W) begin : g_zeroExt
                assign w_outSrc = {{(OUT_W - IN_W){1'b0}}, r_inSr};
            end else begin : g_trunc
                assign w_outSrc = r_inSr[OUT_W-1:0];
            end
        end else begin : g_external
            assign w_outSrc = dut_out;
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_outQ <= '0;
        end else begin
            r_outQ <= w_outSrc;
        end
    end

    // Zero-padded output folded down to one signature-wide word.
    always_comb begin
        w_padded              = '0;
        w_padded[OUT_W-1:0]   = r_outQ;
        w_fold                = '0;
        for (int i = 0; i < c_NUM_CHUNKS; i++) begin
            w_fold = w_fold ^ w_padded[i*SIG_W +: SIG_W];
        end
    end

    assign w_sigNext = {r_sig[SIG_W-2:0], 1'b0}
                     ^ (r_sig[SIG_W-1] ? c_POLY : '0)
                     ^ w_fold;

    // serial_out leads dump_sr by one bit so the first bit is valid on entry.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= c_stateIdle;
            r_sig        <= '0;
            r_dumpSr     <= '0;
            r_bitCnt     <= '0;
            r_cycleCount <= '0;
            r_serialOut  <= 1'b0;
            r_dumpDone   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                c_stateIdle: begin
                    if (start) begin
                        r_sig        <= '0;
                        r_cycleCount <= '0;
                        r_state      <= c_stateRun;
                        r_busy       <= 1'b1;
                    end else if (dump) begin
                        r_dumpSr    <= r_sig;
                        r_bitCnt    <= c_BIT_CNT_W'(SIG_W);
                        r_serialOut <= r_sig[0];
                        r_dumpDone  <= 1'b0;
                        r_state     <= c_stateDump;
                        r_busy      <= 1'b1;
                    end
                end
                c_stateRun: begin
                    if (dump) begin
                        r_dumpSr    <= r_sig;
                        r_bitCnt    <= c_BIT_CNT_W'(SIG_W);
                        r_serialOut <= r_sig[0];
                        r_dumpDone  <= 1'b0;
                        r_state     <= c_stateDump;
                    end else if (start) begin
                        r_sig        <= '0;
                        r_cycleCount <= '0;
                    end else begin
                        r_sig <= w_sigNext;
                        if (r_cycleCount != '1) begin
                            r_cycleCount <= r_cycleCount + CNT_W'(1);
                        end
                    end
                end
                c_stateDump: begin
                    r_dumpSr <= r_dumpSr >> 1;
                    r_bitCnt <= r_bitCnt - c_BIT_CNT_W'(1);
                    if (r_bitCnt == c_BIT_CNT_W'(1)) begin
                        r_state     <= c_stateIdle;
                        r_busy      <= 1'b0;
                        r_serialOut <= 1'b0;
                        r_dumpDone  <= 1'b0;
                    end else begin
                        r_serialOut <= r_dumpSr[1];
                        r_dumpDone  <= (r_bitCnt == c_BIT_CNT_W'(2));
                    end
                end
                default: begin
                    r_state     <= c_stateIdle;
                    r_busy      <= 1'b0;
                    r_serialOut <= 1'b0;
                    r_dumpDone  <= 1'b0;
                end
            endcase
        end
    end

    assign serial_out  = r_serialOut;
    assign dump_done   = r_dumpDone;
    assign busy        = r_busy;
    assign cycle_count = r_cycleCount;

endmodule
`default_nettype wire

// File: tb/tb_synth_io_harness_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_synth_io_harness_gen
// Brief   : Self-checking bench: a loopback instance and a MODE=1 instance
//           with a 12-bit DUT output, sharing clock, reset and control.
// Rev     : 1.0
// ============================================================================
module tb_synth_io_harness_gen;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        serialIn = 1'b0;
    logic        shiftEn = 1'b0;
    logic        start = 1'b0;
    logic        dump = 1'b0;

    logic [7:0]  dutInA;
    logic [7:0]  dutOutA = 8'h00;
    logic        serOutA, doneA, busyA;
    logic [3:0]  cntA;

    logic [7:0]  dutInB;
    logic [11:0] dutOutB = 12'hABC;
    logic        serOutB, doneB, busyB;
    logic [3:0]  cntB;

    always #5 clk = ~clk;

    synth_io_harness_gen #(
        .IN_W(8), .OUT_W(8), .SIG_W(8), .POLY(32'h1D), .MODE(0), .CNT_W(4)
    ) dutA (
        .CLK(clk), .RST_N(rstN), .serial_in(serialIn), .shift_en(shiftEn),
        .start(start), .dump(dump), .dut_in(dutInA), .dut_out(dutOutA),
        .serial_out(serOutA), .dump_done(doneA), .busy(busyA), .cycle_count(cntA)
    );

    synth_io_harness_gen #(
        .IN_W(8), .OUT_W(12), .SIG_W(8), .POLY(32'h1D), .MODE(1), .CNT_W(4)
    ) dutB (
        .CLK(clk), .RST_N(rstN), .serial_in(serialIn), .shift_en(shiftEn),
        .start(start), .dump(dump), .dut_in(dutInB), .dut_out(dutOutB),
        .serial_out(serOutB), .dump_done(doneB), .busy(busyB), .cycle_count(cntB)
    );

    typedef struct {
        logic [7:0] pattern;
        int         nRun;
        logic [7:0] expSig;
    } vec_t;

    vec_t vecs [4];
    bit   sbq [$];
    int   nChecks = 0;
    int   nErrors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] misrModel(input logic [7:0] fold, input int n);
        logic [7:0] s;
        s = 8'h00;
        for (int k = 0; k < n; k++) begin
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ fold;
        end
        return s;
    endfunction

    task automatic shiftByte(input logic [7:0] b);
        shiftEn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            serialIn = b[k];
            tick();
        end
        shiftEn  = 1'b0;
        serialIn = 1'b0;
    endtask

    task automatic pushSig(input logic [7:0] s);
        for (int k = 0; k < 8; k++) sbq.push_back(s[k]);
    endtask

    // Pops one expected bit per busy cycle; bounded so a stuck DUT still ends.
    task automatic collect(input bit sel, input string name);
        int  guard;
        int  idx;
        bit  expBit;
        logic so, dd, bz;
        guard = 0;
        idx   = 0;
        while (sbq.size() > 0 && guard < 16) begin
            so = sel ? serOutB : serOutA;
            dd = sel ? doneB : doneA;
            bz = sel ? busyB : busyA;
            if (bz) begin
                expBit = sbq.pop_front();
                check($sformatf("%s bit%0d", name, idx), {31'b0, so}, {31'b0, expBit});
                check($sformatf("%s done%0d", name, idx), {31'b0, dd}, {31'b0, sbq.size() == 0});
                idx++;
            end
            tick();
            guard++;
        end
        if (sbq.size() != 0) begin
            nChecks++;
            nErrors++;
            $display("FAIL %s timeout: %0d bits still expected, got none", name, sbq.size());
            sbq.delete();
        end
        bz = sel ? busyB : busyA;
        check($sformatf("%s busyAfter", name), {31'b0, bz}, 32'd0);
    endtask

    task automatic doDump(input logic [7:0] expSig, input bit sel, input string name);
        pushSig(expSig);
        dump = 1'b1;
        tick();
        dump = 1'b0;
        collect(sel, name);
    endtask

    task automatic runFor(input int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{pattern: 8'hA5, nRun: 2, expSig: 8'hF2};
        vecs[1] = '{pattern: 8'hFF, nRun: 1, expSig: 8'hFF};
        vecs[2] = '{pattern: 8'h00, nRun: 3, expSig: 8'h00};
        vecs[3] = '{pattern: 8'h3C, nRun: 3, expSig: 8'hB4};

        // Reset state
        repeat (3) tick();
        check("rst serial_out", {31'b0, serOutA}, 32'd0);
        check("rst busy", {31'b0, busyA}, 32'd0);
        check("rst dump_done", {31'b0, doneA}, 32'd0);
        check("rst dut_in", {24'b0, dutInA}, 32'd0);
        check("rst cycle_count", {28'b0, cntA}, 32'd0);
        rstN = 1'b1;
        tick();

        // Deserialise A5, then two RUN cycles and dump
        shiftByte(8'hA5);
        check("deser dut_in", {24'b0, dutInA}, 32'hA5);
        runFor(2);
        check("run2 cycle_count", {28'b0, cntA}, 32'd2);
        doDump(8'hF2, 1'b0, "sigA5");

        // Re-reading from IDLE does not disturb the signature
        doDump(8'hF2, 1'b0, "reread1");
        doDump(8'hF2, 1'b0, "reread2");

        for (int v = 0; v < 4; v++) begin
            shiftByte(vecs[v].pattern);
            check($sformatf("vec%0d dut_in", v), {24'b0, dutInA}, {24'b0, vecs[v].pattern});
            runFor(vecs[v].nRun);
            doDump(vecs[v].expSig, 1'b0, $sformatf("vec%0d", v));
        end

        // Counter saturation at 4'hF
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sat start count", {28'b0, cntA}, 32'd0);
        check("sat busy", {31'b0, busyA}, 32'd1);
        repeat (5) tick();
        check("sat count5", {28'b0, cntA}, 32'd5);
        repeat (15) tick();
        check("sat count20", {28'b0, cntA}, 32'hF);

        // start+dump in RUN: dump wins, signature kept
        pushSig(misrModel(8'h3C, 20));
        start = 1'b1;
        dump  = 1'b1;
        tick();
        start = 1'b0;
        dump  = 1'b0;
        collect(1'b0, "runPrio");

        // start+dump in IDLE: start wins, signature cleared
        start = 1'b1;
        dump  = 1'b1;
        tick();
        start = 1'b0;
        dump  = 1'b0;
        check("idlePrio count", {28'b0, cntA}, 32'd0);
        check("idlePrio busy", {31'b0, busyA}, 32'd1);
        doDump(8'h00, 1'b0, "idlePrio");

        // MODE=1 fold of 12'hABC over one RUN cycle
        runFor(1);
        doDump(8'hB6, 1'b1, "fold");

        // Reset in the middle of a dump
        shiftByte(8'h5A);
        runFor(3);
        dump = 1'b1;
        tick();
        dump = 1'b0;
        tick();
        tick();
        rstN = 1'b0;
        #1;
        check("midRst serial_out", {31'b0, serOutA}, 32'd0);
        check("midRst busy", {31'b0, busyA}, 32'd0);
        check("midRst dut_in", {24'b0, dutInA}, 32'd0);
        check("midRst count", {28'b0, cntA}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("midRst done%0d", k), {31'b0, doneA}, 32'd0);
        end
        rstN = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("postRst done%0d", k), {31'b0, doneA}, 32'd0);
            check($sformatf("postRst busy%0d", k), {31'b0, busyA}, 32'd0);
        end
        runFor(1);
        doDump(8'h00, 1'b0, "afterRst");

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/synth_io_harness_gen.md
Name: synth_io_harness_gen

Overview:
- Parametrised synthesis-measurement harness, successor to the fixed-width null baseline used for LUT accounting of I/O harnesses.
- Deserialises a single input pin into an IN_W-bit DUT input vector.
- Registers and compresses the OUT_W-bit DUT output into a SIG_W-bit MISR signature, then serialises the signature out on one pin.
- MODE=0 is the null loopback baseline; MODE=1 wraps an external DUT.

Parameters:
IN_W, 365, width of the deserialised DUT input vector
OUT_W, 354, width of the DUT output vector
SIG_W, 32, MISR signature width
POLY, 32'h04C11DB7, MISR feedback polynomial, low SIG_W bits used
MODE, 0, 0 = null loopback (outputs taken from input register); 1 = external dut_out
CNT_W, 32, width of the RUN-cycle counter

Ports:
CLK  in  1  single clock, rising edge
RST_N  in  1  asynchronous active-low reset
serial_in  in  1  input bit shifted into the top of the input register
shift_en  in  1  shift enable for the input register
start  in  1  pulse: clear signature, enter RUN
dump  in  1  pulse: snapshot signature, enter DUMP
dut_in  out  IN_W  input shift register contents, driven to the DUT
dut_out  in  OUT_W  DUT outputs; ignored when MODE=0
serial_out  out  1  signature bit, LSB first
dump_done  out  1  one-cycle pulse coincident with the last dumped bit
busy  out  1  high when state != IDLE
cycle_count  out  CNT_W  saturating count of RUN cycles since last start

Behaviour:
Reset (async, RST_N=0):
- in_sr, out_q, sig, dump_sr, bit counter and cycle_count all clear to 0.
- State goes to IDLE.
- serial_out=0, dump_done=0, busy=0.

Input register:
- When shift_en=1: in_sr <= {serial_in, in_sr[IN_W-1:1]}.
- Shifting is independent of FSM state. dut_in = in_sr.

Output capture:
- o_src = MODE==0 ? in_sr[OUT_W-1:0] : dut_out.
- If MODE==0 and OUT_W > IN_W, in_sr is zero-extended.
- out_q <= o_src every cycle, giving 1 cycle of latency.

Fold:
- Zero-pad out_q to a multiple of SIG_W.
- fold = XOR of all SIG_W-bit chunks.

MISR update:
- sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ fold.

FSM:
- IDLE:
  - start=1: sig<=0, cycle_count<=0, go to RUN.
  - dump=1 (and start=0): go to DUMP using the current sig. This allows re-reading the signature.
  - start and dump together: start wins.
- RUN:
  - Each cycle: sig<=sig_next; cycle_count increments, saturating at all-ones.
  - dump=1: go to DUMP. The update in that cycle is NOT applied; dump_sr<=sig, bit counter<=SIG_W.
  - start in RUN: re-clear sig and cycle_count, stay in RUN.
  - start and dump together in RUN: dump wins.
- DUMP:
  - serial_out = dump_sr[0]. Each cycle dump_sr shifts right and the counter decrements.
  - On the cycle with counter==1: dump_done=1, next state IDLE.
  - start and dump are ignored in DUMP. sig is frozen.
- serial_out=0 outside DUMP. dump_done is registered, one pulse per dump.

Reset mid-operation:
- Immediate return to the reset state with no partial dump.
- The next start behaves as after power-up.

Test Plan:
Parameters for tests 1–4: IN_W=8, OUT_W=8, SIG_W=8, POLY=8'h1D, MODE=0, CNT_W=4.
1. Deserialise: shift_en=1 for 8 cycles with serial_in 1,0,1,0,0,1,0,1 -> dut_in=8'hA5; one cycle later out_q=8'hA5.
2. Signature: after test 1, pulse start, allow exactly 2 RUN cycles, then pulse dump -> sig=8'hA5 after cycle 1 and 8'hF2 after cycle 2. serial_out over the next 8 cycles = 0,1,0,0,1,1,1,1. dump_done high only on the 8th bit. busy=0 afterwards.
3. Fold: IN_W=8, OUT_W=12, SIG_W=8, MODE=1, dut_out=12'hABC, start, 1 RUN cycle, dump -> dumped byte 8'hB6.
4. Counter saturation and priority:
   - 20 RUN cycles -> cycle_count=4'hF.
   - start with dump in RUN -> enters DUMP.
   - start with dump in IDLE -> enters RUN with sig=0.
5. Reset mid-DUMP: RST_N low at the 3rd dumped bit -> serial_out=0, busy=0, dut_in=0, dump_done never pulses. A following start and 1 RUN cycle with in_sr=0 -> dumped signature 0.
6. Dump from IDLE twice in succession after test 2 -> both dumps emit 8'hF2 and the signature is unchanged.
